// File: rtl/combo_dialer.sv
// Combination-lock auto-dialer: replays a stored BCD code one digit per
// strobe, then waits for the lock's verdict and reports pass/fail/timeout.
module combo_dialer #(
    parameter int DIGITS  = 6,
    parameter int GAP     = 0,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   code,
    input  logic [3:0]            lock_state,
    output logic [3:0]            digit,
    output logic                  digit_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic                  bad_code
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS  > 1) ? $clog2(DIGITS)  : 1;
    localparam int GW = (GAP     > 1) ? $clog2(GAP)     : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [3:0] LS_OPEN  = 4'b0111;
    localparam logic [3:0] LS_CLOSE = 4'b1000;
    localparam logic [3:0] LS_ERROR = 4'b1001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_shift;
    logic [W-1:0]    w_shift_nxt;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;
    logic [GW-1:0]   r_gap_cnt;
    logic [GW-1:0]   w_gap_nxt;
    logic [TW-1:0]   r_wait_cnt;
    logic [TW-1:0]   w_wait_nxt;

    logic            w_strobe;
    logic [3:0]      w_strobe_digit;
    logic            w_bad_code;
    logic            w_accept;
    logic            w_verdict;

    logic [3:0]      r_digit;
    logic            r_digit_valid;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic            r_fail;
    logic            r_timeout;
    logic            r_bad_code;

    logic [3:0]      w_digit_nxt;
    logic            w_digit_valid_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_pass_nxt;
    logic            w_fail_nxt;
    logic            w_timeout_nxt;
    logic            w_bad_code_nxt;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_verdict = (lock_state == LS_OPEN)  ||
                       (lock_state == LS_CLOSE) ||
                       (lock_state == LS_ERROR);

    always_comb begin
        w_bad_code = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (code[4*i +: 4] > 4'd9) begin
                w_bad_code = 1'b1;
            end
        end
    end

    // Shift register always presents the next digit to send in its MSB nibble.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_idx_nxt      = r_idx;
        w_gap_nxt      = r_gap_cnt;
        w_wait_nxt     = r_wait_cnt;
        w_strobe       = 1'b0;
        w_strobe_digit = r_shift[W-1 -: 4];
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_shift_nxt = code;
                    if (w_bad_code) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt    = S_SEND;
                        w_idx_nxt      = '0;
                        w_strobe       = 1'b1;
                        w_strobe_digit = code[W-1 -: 4];
                        w_shift_nxt    = code << 4;
                    end
                end
            end
            S_SEND: begin
                if (r_idx == IW'(DIGITS - 1)) begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = '0;
                end else if (GAP == 0) begin
                    w_idx_nxt   = r_idx + IW'(1);
                    w_strobe    = 1'b1;
                    w_shift_nxt = r_shift << 4;
                end else begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = '0;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GW'(GAP - 1)) begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = r_idx + IW'(1);
                    w_strobe    = 1'b1;
                    w_shift_nxt = r_shift << 4;
                end else begin
                    w_gap_nxt = r_gap_cnt + GW'(1);
                end
            end
            S_WAIT: begin
                if (w_verdict || (r_wait_cnt == TW'(TIMEOUT - 1))) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_wait_nxt = r_wait_cnt + TW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are computed for the upcoming state so they can be registered.
    always_comb begin
        w_digit_nxt       = w_strobe ? w_strobe_digit : 4'h0;
        w_digit_valid_nxt = w_strobe;
        w_busy_nxt        = (w_state_nxt != S_IDLE);
        w_done_nxt        = (w_state_nxt == S_DONE);
        w_pass_nxt        = r_pass;
        w_fail_nxt        = r_fail;
        w_timeout_nxt     = r_timeout;
        w_bad_code_nxt    = r_bad_code;
        if (w_accept) begin
            w_pass_nxt     = 1'b0;
            w_fail_nxt     = w_bad_code;
            w_timeout_nxt  = 1'b0;
            w_bad_code_nxt = w_bad_code;
        end else if ((r_state == S_WAIT) && (w_state_nxt == S_DONE)) begin
            if (lock_state == LS_OPEN) begin
                w_pass_nxt = 1'b1;
            end else begin
                w_fail_nxt    = 1'b1;
                w_timeout_nxt = !w_verdict;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_idx         <= '0;
            r_gap_cnt     <= '0;
            r_wait_cnt    <= '0;
            r_digit       <= 4'h0;
            r_digit_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_bad_code    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_idx         <= w_idx_nxt;
            r_gap_cnt     <= w_gap_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_digit       <= w_digit_nxt;
            r_digit_valid <= w_digit_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_pass        <= w_pass_nxt;
            r_fail        <= w_fail_nxt;
            r_timeout     <= w_timeout_nxt;
            r_bad_code    <= w_bad_code_nxt;
        end
    end

    assign digit       = r_digit;
    assign digit_valid = r_digit_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign bad_code    = r_bad_code;

endmodule

// File: tb/tb_combo_dialer.sv
// Bench for combo_dialer: directed plus randomized attempts on a GAP=0 and a
// GAP=2 instance, checked cycle by cycle against an arithmetic timeline model.
module tb_combo_dialer;

    localparam int DIGITS  = 6;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0;
    logic        start2;
    logic [23:0] code;
    logic [3:0]  lock_state;

    logic [3:0]  digit0, digit2;
    logic        dv0, dv2, busy0, busy2, done0, done2;
    logic        pass0, pass2, fail0, fail2, to0, to2, bad0, bad2;
    logic [10:0] o0, o2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    combo_dialer #(.DIGITS(DIGITS), .GAP(0), .TIMEOUT(TIMEOUT)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .code(code),
        .lock_state(lock_state), .digit(digit0), .digit_valid(dv0),
        .busy(busy0), .done(done0), .pass(pass0), .fail(fail0),
        .timeout(to0), .bad_code(bad0)
    );

    combo_dialer #(.DIGITS(DIGITS), .GAP(2), .TIMEOUT(TIMEOUT)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .code(code),
        .lock_state(lock_state), .digit(digit2), .digit_valid(dv2),
        .busy(busy2), .done(done2), .pass(pass2), .fail(fail2),
        .timeout(to2), .bad_code(bad2)
    );

    assign o0 = {digit0, dv0, busy0, done0, pass0, fail0, to0, bad0};
    assign o2 = {digit2, dv2, busy2, done2, pass2, fail2, to2, bad2};

    function automatic logic [3:0] nib(input logic [23:0] cd, input int k);
        logic [23:0] t;
        t = cd >> (4 * (DIGITS - 1 - k));
        return t[3:0];
    endfunction

    function automatic logic [3:0] busy_ls();
        int r;
        r = $urandom_range(0, 12);
        return (r >= 7) ? 4'(r + 3) : 4'(r);
    endfunction

    task automatic check(input string tag, input int c,
                         input logic [10:0] got, input logic [10:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, got, exp);
        end
    endtask

    // v: WAIT edge (1-based) at which the verdict vv first appears; 0 = lock
    // held at 0000 forever. rst_at: cycle during which reset is pulled low.
    task automatic attempt(input int g, input logic [23:0] cd,
                           input logic [3:0] vv, input int v,
                           input int extra, input int rst_at,
                           input string tag);
        int          last, d, n;
        bit          bad, to;
        logic        e_dv, e_pass, e_fail, e_to, e_bad;
        logic [3:0]  e_dig;
        logic [10:0] exp, got;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (nib(cd, k) > 4'd9) bad = 1'b1;
        end
        last = 1 + (DIGITS - 1) * (g + 1);
        to   = 1'b0;
        if (bad) begin
            d = 1;
        end else if (v >= 1 && v <= TIMEOUT) begin
            d = last + 1 + v;
        end else begin
            d  = last + 1 + TIMEOUT;
            to = 1'b1;
        end
        n = (rst_at > 0) ? rst_at + 3 : d + 2;
        code = cd;
        if (g == 0) start0 = 1'b1;
        else        start2 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
        for (int c = 1; c <= n; c++) begin
            reset = (rst_at > 0 && c == rst_at) ? 1'b0 : 1'b1;
            if (v > 0 && c >= last + v)  lock_state = vv;
            else if (v == 0)             lock_state = 4'h0;
            else if (c <= last)          lock_state = 4'($urandom_range(0, 15));
            else                         lock_state = busy_ls();
            if (c == extra && c < d) begin
                if (g == 0) start0 = 1'b1;
                else        start2 = 1'b1;
            end else begin
                start0 = 1'b0;
                start2 = 1'b0;
            end
            @(negedge clk);
            e_dv   = !bad && c <= last && ((c - 1) % (g + 1)) == 0;
            e_dig  = e_dv ? nib(cd, (c - 1) / (g + 1)) : 4'h0;
            e_pass = 1'b0;
            e_fail = 1'b0;
            e_to   = 1'b0;
            e_bad  = 1'b0;
            if (c >= d) begin
                if (bad) begin
                    e_fail = 1'b1;
                    e_bad  = 1'b1;
                end else if (to) begin
                    e_fail = 1'b1;
                    e_to   = 1'b1;
                end else begin
                    e_pass = (vv == 4'b0111);
                    e_fail = (vv != 4'b0111);
                end
            end
            exp = {e_dig, e_dv, (c <= d), (c == d), e_pass, e_fail, e_to, e_bad};
            if (rst_at > 0 && c > rst_at) exp = '0;
            got = (g == 0) ? o0 : o2;
            check(tag, c, got, exp);
            @(posedge clk);
            #1;
        end
        reset      = 1'b1;
        start0     = 1'b0;
        start2     = 1'b0;
        lock_state = 4'h0;
    endtask

    initial begin
        logic [23:0] cd;
        logic [3:0]  vv;
        int          g, v, pos;

        reset      = 1'b0;
        start0     = 1'b1;
        start2     = 1'b1;
        code       = 24'h305464;
        lock_state = 4'h0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_g0", 0, o0, 11'h0);
            check("reset_g2", 0, o2, 11'h0);
        end
        @(posedge clk);
        #1;
        reset  = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        @(negedge clk);
        check("release_g0", 0, o0, 11'h0);
        @(posedge clk);
        @(negedge clk);
        check("idle_g0", 1, o0, 11'h0);
        check("idle_g2", 1, o2, 11'h0);
        @(posedge clk);
        #1;

        attempt(0, 24'h305464, 4'b0111, 2, 0, 0, "happy");
        attempt(0, 24'h305465, 4'b1000, 1, 0, 0, "wrong_close");
        attempt(0, 24'h305465, 4'b1001, 1, 0, 0, "wrong_error");
        attempt(0, 24'h30A464, 4'b0111, 1, 0, 0, "bad_code");
        attempt(0, 24'h305464, 4'b0111, 0, 4, 0, "timeout");
        attempt(0, 24'h123456, 4'b0111, TIMEOUT, 0, 0, "verdict_last_edge");
        attempt(0, 24'h987654, 4'b0111, TIMEOUT + 1, 0, 0, "verdict_too_late");
        attempt(2, 24'h305464, 4'b0111, 1, 0, 8, "gap_reset");
        attempt(2, 24'h305464, 4'b0111, 2, 0, 0, "gap_fresh");
        attempt(2, 24'h99F000, 4'b1000, 1, 0, 0, "gap_bad_code");

        for (int i = 0; i < 10; i++) begin
            g  = (i % 2 == 0) ? 0 : 2;
            cd = '0;
            for (int k = 0; k < DIGITS; k++) begin
                cd = {cd[19:0], 4'($urandom_range(0, 9))};
            end
            if ($urandom_range(0, 3) == 0) begin
                pos = $urandom_range(0, DIGITS - 1);
                cd[4*pos +: 4] = 4'($urandom_range(10, 15));
            end
            case ($urandom_range(0, 2))
                0:       vv = 4'b0111;
                1:       vv = 4'b1000;
                default: vv = 4'b1001;
            endcase
            v = $urandom_range(0, TIMEOUT + 2);
            attempt(g, cd, vv, v, $urandom_range(2, 6), 0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/combo_dialer.md
Name: combo_dialer

Overview:
- Initiator side of the combination-lock digit interface: replays a stored N-digit BCD code into the lock one digit per strobe, then watches the lock's status code and reports pass/fail.
- Used as an auto-entry driver on the DE1-SoC top level and as a self-test source for the lock FSM.
- Digit 0 (first entered) sits in the MSB nibble of `code`.

Parameters:
- DIGITS, 6: number of digits sent per attempt.
- GAP, 0: idle cycles inserted between consecutive digit strobes (0 = back-to-back).
- TIMEOUT, 16: maximum WAIT cycles for a lock verdict before declaring timeout (>=1).

Ports:
- clk  input  1  rising-edge clock (KEY[0] at top level)
- reset  input  1  synchronous, active-low reset (KEY[3] at top level)
- start  input  1  begin an attempt; sampled only in IDLE
- code  input  4*DIGITS  BCD combination; nibble [4*DIGITS-1:4*DIGITS-4] is sent first
- lock_state  input  4  lock status: 4'b0111 open, 4'b1000 close, 4'b1001 error; other values mean still in progress
- digit  output  4  current digit; 4'b0000 whenever digit_valid=0
- digit_valid  output  1  one-cycle strobe per digit
- busy  output  1  high in SEND, GAP, WAIT, DONE
- done  output  1  one-cycle pulse at end of attempt
- pass  output  1  lock reported open; held until next accepted start
- fail  output  1  close/error/timeout/bad code; held until next accepted start
- timeout  output  1  no verdict within TIMEOUT cycles; held
- bad_code  output  1  some nibble of code > 9; held

Behaviour:
- All outputs registered. State encoding: IDLE, SEND, GAP, WAIT, DONE.
- Reset: reset==0 at a clk edge forces IDLE next cycle with all outputs 0 and all counters 0. Reset overrides every state, including mid-SEND; no partial digit is emitted afterward.
- IDLE, start=1 at edge t0:
  - Latch code into the shift register.
  - Clear pass/fail/timeout/bad_code.
  - If any nibble > 9: go to DONE, set fail=1 and bad_code=1. No digit_valid is ever asserted.
  - Otherwise: go to SEND with idx=0.
- SEND:
  - digit_valid=1 and digit=nibble idx for exactly one cycle. The first strobe is the cycle after t0.
  - If idx==DIGITS-1: go to WAIT.
  - Else if GAP==0: stay in SEND with idx+1.
  - Else: go to GAP.
  - With GAP=0, strobes occupy cycles t0+1 .. t0+DIGITS. With GAP=g, strobes are spaced g+1 cycles apart.
- GAP: count g cycles with digit_valid=0, then return to SEND with idx+1.
- WAIT:
  - wait_cnt is zeroed on entry. lock_state is sampled at each edge.
  - 0111: go to DONE, pass=1.
  - 1000 or 1001: go to DONE, fail=1.
  - Otherwise, if wait_cnt==TIMEOUT-1: go to DONE, fail=1, timeout=1.
  - Otherwise: wait_cnt+1.
  - A verdict present on the final timeout edge takes priority over timeout.
  - lock_state is ignored outside WAIT.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE. start is ignored in DONE and in every non-IDLE state; it is not queued.
- Invariant: pass, fail and timeout are mutually consistent (pass excludes fail; timeout implies fail; bad_code implies fail).
- idx and wait_cnt widths: $clog2 of their ranges, minimum 1 bit. No wrap-around is possible within one attempt.

Test Plan:
- Reset: hold reset=0 for 2 edges with start=1 and code=24'h305464. Every output must be 0 throughout, and stay 0 for 1 cycle after release with start=0.
- Happy path (GAP=0): start for one cycle with code 24'h305464. digit_valid must be high on cycles t0+1..t0+6 carrying 3,0,5,4,6,4. Lock model drives 0111 at the 2nd WAIT edge. Require done at one cycle only, pass=1, fail=0; busy falls the cycle after done.
- Wrong code: code 24'h305465, lock drives 1000 after the last digit. Require fail=1, pass=0, timeout=0. Repeat with 1001: same result.
- Bad code: code 24'h30A464. Require done at t0+1, fail=1 and bad_code=1, and no digit_valid at any point.
- Timeout (TIMEOUT=16): lock_state held 0000. Require exactly 16 WAIT cycles, then done with fail=1 and timeout=1. A second start during busy is ignored; a start in IDLE afterward clears the flags.
- GAP=2 plus mid-run reset: strobes at t0+1, t0+4, t0+7. Assert reset=0 just after the 3rd strobe. Require all outputs 0 the next cycle and no further strobes; a fresh start then completes normally.
